dct_serial_rx: RTL and testbench

Parametrised bit-serial receive front end for the DCT engine, successor to the fixed single-lane iSDAT/iSVAL input path. It deserialises LANES parallel bit-serial streams into DATA_W-bit samples, groups them into frames of N = 4/8/16/32 points selected per frame by iSize, and buffers frames in a ping-pong store. Complete frames are presented to the transform core in index order over a valid/ready handshake.

---
 rtl/dct_io_pkg.sv | 23 ++
 rtl/dct_rx_deser.sv | 25 ++
 rtl/dct_serial_rx.sv | 148 ++++++++++++++
 tb/tb_dct_serial_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_io_pkg.sv
// dct_io_pkg: shared serial I/O defaults, bank state and size-code decoding for the DCT rx/tx paths.
package dct_io_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_LOG2N_DEF = 5;

    typedef logic [2:0] log2n_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_st_e;

    function automatic logic size_err(input logic [2:0] code, input log2n_t max_log2n);
        return code > max_log2n - 3'd2;
    endfunction

    // Codes beyond the store depth clamp to the largest frame.
    function automatic log2n_t size_log2n(input logic [2:0] code, input log2n_t max_log2n);
        return size_err(code, max_log2n) ? max_log2n : code + 3'd2;
    endfunction
endpackage

// File: rtl/dct_rx_deser.sv
// dct_rx_deser: one lane's MSB-first shift register with an even-parity check on the trailing bit.
module dct_rx_deser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              chk,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              par_err
);
    logic [DATA_W-1:0] sr;

    // data is the sample as it will look after this cycle's bit lands
    assign data    = shift ? {sr[DATA_W-2:0], din} : sr;
    assign par_err = chk && ((^sr) != din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr <= '0;
        else if (shift)
            sr <= data;
    end
endmodule

// File: rtl/dct_serial_rx.sv
// dct_serial_rx: LANES-lane bit-serial sample receiver with ping-pong frame store and in-order readout.
// Define DCT_RX_PARITY_EN to expect one even-parity bit per lane after every sample.
module dct_serial_rx
    import dct_io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LANES     = 1,
    parameter int MAX_LOG2N = MAX_LOG2N_DEF
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [LANES-1:0]     iSDAT,
    input  logic                 iSVAL,
    input  logic [2:0]           iSize,
    output logic [DATA_W-1:0]    oSample,
    output logic [MAX_LOG2N-1:0] oIndex,
    output logic                 oValid,
    input  logic                 iReady,
    output logic                 oLast,
    output logic                 oErr,
    output logic                 oOvf
);
`ifdef DCT_RX_PARITY_EN
    localparam int GRP = DATA_W + 1;
`else
    localparam int GRP = DATA_W;
`endif
    localparam int     BW    = $clog2(GRP + 1);
    localparam int     CW    = MAX_LOG2N + 1;
    localparam int     DEPTH = 1 << MAX_LOG2N;
    localparam log2n_t MAXL  = log2n_t'(MAX_LOG2N);

    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     samp_cnt;
    logic              in_frame;
    logic              drop_r;
    log2n_t            log2n_r;
    logic              wr_bank;
    logic              rd_bank;
    bank_st_e          bank_st [2];
    log2n_t            bank_log2n [2];
    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [DATA_W-1:0] lane_data [LANES];
    logic [LANES-1:0]  par_err;

    logic                 first, drop, shift, chk, grp_done, frame_done;
    log2n_t               log2n;
    logic [CW-1:0]        samp_nxt;
    logic                 hs, rel, adv, step, start, nxt_bank;
    logic [MAX_LOG2N-1:0] nxt_idx;
    logic [CW-1:0]        nxt_n;

    // Frame parameters come live from the inputs on the first bit, then from the registered copy.
    assign first      = iSVAL && !in_frame;
    assign log2n      = in_frame ? log2n_r : size_log2n(iSize, MAXL);
    assign drop       = in_frame ? drop_r : (bank_st[wr_bank] != BANK_EMPTY);
    assign shift      = iSVAL && (bit_cnt < BW'(DATA_W));
    assign chk        = iSVAL && (bit_cnt == BW'(DATA_W));
    assign grp_done   = iSVAL && (bit_cnt == BW'(GRP - 1));
    assign samp_nxt   = samp_cnt + CW'(LANES);
    assign frame_done = grp_done && (samp_nxt == (CW'(1) << log2n));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dct_rx_deser #(.DATA_W(DATA_W)) u_deser (
            .clk     (iClk),
            .rst_n   (iRst_n),
            .shift   (shift),
            .chk     (chk),
            .din     (iSDAT[k]),
            .data    (lane_data[k]),
            .par_err (par_err[k])
        );
    end

    // Reader: banks are filled and drained in strict alternation, so rd_bank is always the oldest.
    assign hs       = oValid && iReady;
    assign rel      = hs && oLast;
    assign adv      = !oValid || hs;
    assign step     = hs && !oLast;
    assign nxt_bank = rel ? !rd_bank : rd_bank;
    assign start    = adv && (!oValid || oLast) && (bank_st[nxt_bank] == BANK_FULL);
    assign nxt_idx  = step ? oIndex + 1'b1 : '0;
    assign nxt_n    = CW'(1) << bank_log2n[nxt_bank];

    always_ff @(posedge iClk) begin
        if (grp_done && !drop)
            for (int i = 0; i < LANES; i++)
                mem[wr_bank][samp_cnt[MAX_LOG2N-1:0] + MAX_LOG2N'(i)] <= lane_data[i];
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bit_cnt       <= '0;
            samp_cnt      <= '0;
            in_frame      <= 1'b0;
            drop_r        <= 1'b0;
            log2n_r       <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            bank_st[0]    <= BANK_EMPTY;
            bank_st[1]    <= BANK_EMPTY;
            bank_log2n[0] <= '0;
            bank_log2n[1] <= '0;
            oSample       <= '0;
            oIndex        <= '0;
            oValid        <= 1'b0;
            oLast         <= 1'b0;
            oErr          <= 1'b0;
            oOvf          <= 1'b0;
        end else begin
            oErr <= (first && size_err(iSize, MAXL)) || (|par_err);
            oOvf <= first && drop;
            if (iSVAL)
                bit_cnt <= grp_done ? '0 : bit_cnt + 1'b1;
            if (first) begin
                in_frame <= 1'b1;
                log2n_r  <= log2n;
                drop_r   <= drop;
                if (!drop) begin
                    bank_st[wr_bank]    <= BANK_FILLING;
                    bank_log2n[wr_bank] <= log2n;
                end
            end
            if (grp_done)
                samp_cnt <= frame_done ? '0 : samp_nxt;
            // A dropped frame still runs its full bit count so the next boundary stays aligned.
            if (frame_done) begin
                in_frame <= 1'b0;
                if (!drop) begin
                    bank_st[wr_bank] <= BANK_FULL;
                    wr_bank          <= !wr_bank;
                end
            end
            if (adv) begin
                oValid  <= step || start;
                oIndex  <= nxt_idx;
                oSample <= (step || start) ? mem[nxt_bank][nxt_idx] : '0;
                oLast   <= (step || start) && ({1'b0, nxt_idx} == nxt_n - 1'b1);
            end
            if (rel) begin
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= !rd_bank;
            end
            if (start)
                bank_st[nxt_bank] <= BANK_READING;
        end
    end
endmodule

// File: tb/tb_dct_serial_rx.sv
// tb_dct_serial_rx: directed checks on a 1-lane and a 2-lane receiver sharing clock and reset.
module tb_dct_serial_rx;
    localparam int DW = 16;
`ifdef DCT_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [0:0]    sdat_a = '0;
    logic          sval_a = 1'b0, rdy_a = 1'b0;
    logic [2:0]    size_a = '0;
    logic [DW-1:0] smp_a;
    logic [4:0]    idx_a;
    logic          vld_a, last_a, err_a, ovf_a;

    logic [1:0]    sdat_b = '0;
    logic          sval_b = 1'b0, rdy_b = 1'b0;
    logic [2:0]    size_b = '0;
    logic [DW-1:0] smp_b;
    logic [4:0]    idx_b;
    logic          vld_b, last_b, err_b, ovf_b;

    dct_serial_rx #(.DATA_W(DW), .LANES(1), .MAX_LOG2N(5)) u_dut_a (
        .iClk(clk), .iRst_n(rst_n), .iSDAT(sdat_a), .iSVAL(sval_a), .iSize(size_a),
        .oSample(smp_a), .oIndex(idx_a), .oValid(vld_a), .iReady(rdy_a),
        .oLast(last_a), .oErr(err_a), .oOvf(ovf_a)
    );

    dct_serial_rx #(.DATA_W(DW), .LANES(2), .MAX_LOG2N(5)) u_dut_b (
        .iClk(clk), .iRst_n(rst_n), .iSDAT(sdat_b), .iSVAL(sval_b), .iSize(size_b),
        .oSample(smp_b), .oIndex(idx_b), .oValid(vld_b), .iReady(rdy_b),
        .oLast(last_b), .oErr(err_b), .oOvf(ovf_b)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int n, input int nn, input logic [15:0] s);
        return {10'b0, n == nn - 1, 5'(n), s};
    endfunction

    logic [21:0] qa[$], qb[$];
    int          qca[$];
    int          err_cnt_a = 0, ovf_cnt_a = 0, err_cyc_a = 0, ovf_cyc_a = 0;
    int          start_a = 0, par_cyc = 0;

    // Output monitor: records handshakes, counts pulses, and checks that a stalled output holds.
    initial begin
        logic        hold_a;
        logic [22:0] hold_val;
        hold_a = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (hold_a && rst_n)
                chk("hold", 32'({vld_a, last_a, idx_a, smp_a}), 32'(hold_val));
            hold_a   = rst_n && vld_a && !rdy_a;
            hold_val = {vld_a, last_a, idx_a, smp_a};
            if (vld_a && rdy_a) begin
                qa.push_back({last_a, idx_a, smp_a});
                qca.push_back(cyc);
            end
            if (vld_b && rdy_b)
                qb.push_back({last_b, idx_b, smp_b});
            if (err_a) begin
                err_cnt_a++;
                err_cyc_a = cyc;
            end
            if (ovf_a) begin
                ovf_cnt_a++;
                ovf_cyc_a = cyc;
            end
        end
    end

    task automatic send_a(input logic [15:0] s[$], input logic [2:0] sz, input int flip);
        size_a  = sz;
        start_a = cyc;
        foreach (s[n]) begin
            for (int b = DW - 1; b >= 0; b--) begin
                sval_a = 1'b1;
                sdat_a = s[n][b];
                @(posedge clk); #1;
            end
            if (PB == 1) begin
                sval_a = 1'b1;
                sdat_a = (^s[n]) ^ (n == flip);
                if (n == flip)
                    par_cyc = cyc;
                @(posedge clk); #1;
            end
        end
        sval_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] s[$], input logic [2:0] sz, input int gap);
        size_b = sz;
        for (int g = 0; g < s.size(); g += 2) begin
            for (int b = DW - 1 + PB; b >= 0; b--) begin
                while (gap > 0 && $urandom_range(99) < gap) begin
                    sval_b = 1'b0;
                    sdat_b = 2'($urandom_range(3));
                    @(posedge clk); #1;
                end
                sval_b = 1'b1;
                sdat_b = (b == DW) ? {^s[g + 1], ^s[g]} : {s[g + 1][b % DW], s[g][b % DW]};
                @(posedge clk); #1;
            end
        end
        sval_b = 1'b0;
    endtask

    task automatic wait_q(input int n, input bit b);
        int t = 0;
        while ((b ? qb.size() : qa.size()) < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk(b ? "qb_count" : "qa_count", b ? qb.size() : qa.size(), n);
    endtask

    task automatic chk_frame(input string tag, input bit b, input int base, input logic [15:0] s[$], input int nn);
        foreach (s[n])
            chk($sformatf("%s[%0d]", tag, n), b ? 32'(qb[base + n]) : 32'(qa[base + n]), ent(n, nn, s[n]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f1[$], g8[$], fa[$], fb[$], fc[$], fd[$], big[$], part[$];
        int st;
        f1 = '{16'h0001, 16'h8000, 16'h7FFF, 16'h1234};
        g8 = '{16'h0102, 16'hF00F, 16'h00FF, 16'hFF00, 16'hAAAA, 16'h5555, 16'h8001, 16'h7FFE};
        fa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        fb = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
        fc = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        fd = '{16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468};
        for (int n = 0; n < 32; n++)
            big.push_back(16'(16'hA500 + n));
        for (int n = 0; n < 10; n++)
            part.push_back(big[n]);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 32'({vld_a, last_a, idx_a, smp_a, err_a, ovf_a}), 32'd0);
        chk("rst_b", 32'({vld_b, last_b, idx_b, smp_b, err_b, ovf_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-lane, 4 points, latency from last bit
        rdy_a = 1'b1;
        send_a(f1, 3'd0, -1);
        chk("lat_pre", 32'(vld_a), 32'd0);
        @(posedge clk); #1;
        chk("lat_idx0", 32'({vld_a, idx_a, smp_a}), 32'({1'b1, 5'd0, 16'h0001}));
        wait_q(4, 1'b0);
        chk_frame("t1", 1'b0, 0, f1, 4);
        chk("t1_err", err_cnt_a, 0);

        // 2-lane, 8 points, gapless then with random gaps
        rdy_b = 1'b1;
        send_b(g8, 3'd1, 0);
        wait_q(8, 1'b1);
        chk_frame("t2_nogap", 1'b1, 0, g8, 8);
        send_b(g8, 3'd1, 40);
        wait_q(16, 1'b1);
        chk_frame("t2_gap", 1'b1, 8, g8, 8);

        // overflow: two frames stall, third dropped, fourth accepted
        qa.delete();
        qca.delete();
        rdy_a = 1'b0;
        send_a(fa, 3'd0, -1);
        send_a(fb, 3'd0, -1);
        chk("t3_no_ovf", ovf_cnt_a, 0);
        send_a(fc, 3'd0, -1);
        st = start_a;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_ovf_cnt", ovf_cnt_a, 1);
        chk("t3_ovf_cyc", ovf_cyc_a, st + 1);
        chk("t3_stall", 32'({vld_a, idx_a, smp_a}), 32'({1'b1, 5'd0, fa[0]}));
        rdy_a = 1'b1;
        wait_q(8, 1'b0);
        chk_frame("t3_f1", 1'b0, 0, fa, 4);
        chk_frame("t3_f2", 1'b0, 4, fb, 4);
        chk("t3_nobubble", qca[4], qca[3] + 1);
        send_a(fd, 3'd0, -1);
        wait_q(12, 1'b0);
        chk_frame("t3_f4", 1'b0, 8, fd, 4);
        chk("t3_ovf_final", ovf_cnt_a, 1);

        // illegal size clamps to 32 points
        qa.delete();
        err_cnt_a = 0;
        send_a(big, 3'd7, -1);
        st = start_a;
        wait_q(32, 1'b0);
        chk_frame("t4", 1'b0, 0, big, 32);
        chk("t4_err_cnt", err_cnt_a, 1);
        chk("t4_err_cyc", err_cyc_a, st + 1);

        // reset with one full bank stalled and a partial frame in flight
        qa.delete();
        rdy_a = 1'b0;
        send_a(fa, 3'd0, -1);
        send_a(part, 3'd3, -1);
        chk("t5_pre_vld", 32'(vld_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst", 32'({vld_a, last_a, idx_a, smp_a, err_a, ovf_a}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        qa.delete();
        rdy_a = 1'b1;
        send_a(fd, 3'd0, -1);
        wait_q(4, 1'b0);
        chk_frame("t5", 1'b0, 0, fd, 4);

`ifdef DCT_RX_PARITY_EN
        // bad parity on 0x0003 still stores the sample
        begin
            logic [15:0] pf[$];
            pf = '{16'h0003, 16'h0101, 16'h0F00, 16'h0000};
            qa.delete();
            err_cnt_a = 0;
            send_a(pf, 3'd0, 0);
            wait_q(4, 1'b0);
            chk_frame("t6", 1'b0, 0, pf, 4);
            chk("t6_err_cnt", err_cnt_a, 1);
            chk("t6_err_cyc", err_cyc_a, par_cyc + 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
